// File: rtl/spi_slave_core.sv
// Oversampled SPI slave core. All logic runs on wb_clk_i; the SPI pins are
// synchronised, edge-detected, and turned into sample/shift strobes. Each word
// has a TX holding register and RX valid/ready handshakes around it.
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_pad_o,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            IDLE_LVL = (CPOL != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]   ss_sync_q, ss_sync_d;
  logic                     sclk_prev_q, sclk_prev_d;
  logic                     ss_prev_q, ss_prev_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]        shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0]        shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0]        hold_q, hold_d;
  logic                     tx_full_q, tx_full_d;
  logic [DATA_W-1:0]        rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     miso_q, miso_d;
  logic                     urun_pend_q, urun_pend_d;
  logic                     tx_underrun_q, tx_underrun_d;
  logic                     rx_overrun_q, rx_overrun_d;
  logic                     frame_abort_q, frame_abort_d;

  logic                     sclk_s, mosi_s, ss_s;
  logic                     lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
  logic                     load, word_done;
  logic [DATA_W-1:0]        load_word, word;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  // SCLK edges only count while the slave is selected.
  assign lead_edge   = (sclk_prev_q == IDLE_LVL) && (sclk_s != IDLE_LVL) && !ss_s;
  assign trail_edge  = (sclk_prev_q != IDLE_LVL) && (sclk_s == IDLE_LVL) && !ss_s;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q && !ss_s;

  // Pin synchroniser shift chains and edge-detect history.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_pad_o};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  // Frame FSM, shift registers, holding register and RX handshake.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    hold_d        = hold_q;
    tx_full_d     = tx_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    miso_d        = miso_q;
    urun_pend_d   = urun_pend_q;
    tx_underrun_d = 1'b0;
    rx_overrun_d  = 1'b0;
    frame_abort_d = 1'b0;
    load          = 1'b0;
    word_done     = 1'b0;
    load_word     = tx_full_q ? hold_q : '0;
    word          = shift_in(shift_rx_q, mosi_s);

    case (state_q)
      IDLE: begin
        miso_d      = 1'b0;
        urun_pend_d = 1'b0;
        if (ss_fall) begin
          state_d       = SHIFT;
          bit_cnt_d     = '0;
          load          = 1'b1;
          tx_underrun_d = !tx_full_q;
          // CPHA=0 must present the first bit before the first sample edge.
          if (CPHA != 0) begin
            shift_tx_d = load_word;
          end else begin
            shift_tx_d = shift_out(load_word);
            miso_d     = first_bit(load_word);
          end
        end
      end
      SHIFT: begin
        if (ss_s) begin
          state_d       = IDLE;
          bit_cnt_d     = '0;
          urun_pend_d   = 1'b0;
          frame_abort_d = (bit_cnt_q != '0);
        end else begin
          if (sample_edge) begin
            shift_rx_d = word;
            // An empty reload only counts as underrun once the next word really starts.
            if ((bit_cnt_q == '0) && urun_pend_q) begin
              tx_underrun_d = 1'b1;
              urun_pend_d   = 1'b0;
            end
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d   = '0;
              word_done   = 1'b1;
              load        = 1'b1;
              urun_pend_d = !tx_full_q;
              if (CPHA != 0) begin
                shift_tx_d = load_word;
              end else begin
                shift_tx_d = shift_out(load_word);
                miso_d     = first_bit(load_word);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // With CPHA=0 the trailing edge after a completed word must not advance the new word.
          if (shift_edge && ((CPHA != 0) || (bit_cnt_q != '0))) begin
            miso_d     = first_bit(shift_tx_q);
            shift_tx_d = shift_out(shift_tx_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) tx_full_d = 1'b0;
    if (tx_valid && !tx_full_q) begin
      hold_d    = tx_data;
      tx_full_d = 1'b1;
    end

    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sclk_sync_q   <= {SYNC_STAGES{IDLE_LVL}};
      sclk_prev_q   <= IDLE_LVL;
      ss_sync_q     <= '0;
      ss_prev_q     <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      tx_full_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      miso_q        <= 1'b0;
      urun_pend_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      ss_sync_q     <= ss_sync_d;
      ss_prev_q     <= ss_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_full_q     <= tx_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      miso_q        <= miso_d;
      urun_pend_q   <= urun_pend_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Datapath registers; their contents are qualified by the control state.
  always_ff @(posedge wb_clk_i) begin
    mosi_sync_q <= mosi_sync_d;
    shift_tx_q  <= shift_tx_d;
    shift_rx_q  <= shift_rx_d;
    hold_q      <= hold_d;
  end

  assign busy        = (state_q == SHIFT);
  assign miso_oe     = busy;
  assign miso        = miso_oe & miso_q;
  assign tx_ready    = !tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: three instances (mode 0 / 8 bit, mode 3 / 16 bit,
// mode 0 LSB-first / 8 bit) sharing sclk and mosi, each with its own select.
module tb_spi_slave_core;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst, sclk, mosi, ss0, ss1, ss2;

  logic        miso0, oe0, tx_valid0, tx_ready0, rx_valid0, rx_ready0, busy0, ovr0, urun0, abort0;
  logic [7:0]  tx_data0, rx_data0;
  logic        miso1, oe1, tx_valid1, tx_ready1, rx_valid1, rx_ready1, busy1, ovr1, urun1, abort1;
  logic [15:0] tx_data1, rx_data1;
  logic        miso2, oe2, tx_valid2, tx_ready2, rx_valid2, rx_ready2, busy2, ovr2, urun2, abort2;
  logic [7:0]  tx_data2, rx_data2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_urun0 = 0, n_ovr0 = 0, n_abort0 = 0, n_urun1 = 0, n_ovr1 = 0;
  logic [15:0] rxq1[$];

  spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) u_m0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .sclk(sclk), .mosi(mosi), .ss_pad_o(ss0),
    .miso(miso0), .miso_oe(oe0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .busy(busy0),
    .rx_overrun(ovr0), .tx_underrun(urun0), .frame_abort(abort0));

  spi_slave_core #(.DATA_W(16), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(2)) u_m3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .sclk(sclk), .mosi(mosi), .ss_pad_o(ss1),
    .miso(miso1), .miso_oe(oe1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .busy(busy1),
    .rx_overrun(ovr1), .tx_underrun(urun1), .frame_abort(abort1));

  spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .SYNC_STAGES(2)) u_lsb (
    .wb_clk_i(clk), .wb_rst_i(rst), .sclk(sclk), .mosi(mosi), .ss_pad_o(ss2),
    .miso(miso2), .miso_oe(oe2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2), .busy(busy2),
    .rx_overrun(ovr2), .tx_underrun(urun2), .frame_abort(abort2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (urun0)  n_urun0  <= n_urun0 + 1;
    if (ovr0)   n_ovr0   <= n_ovr0 + 1;
    if (abort0) n_abort0 <= n_abort0 + 1;
    if (urun1)  n_urun1  <= n_urun1 + 1;
    if (ovr1)   n_ovr1   <= n_ovr1 + 1;
    if (rx_valid1 && rx_ready1) rxq1.push_back(rx_data1);
  end

  typedef struct {
    logic [7:0] tx;
    bit         tx_en;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
    int         exp_urun;
  } vec_t;

  vec_t tbl [4];

  task automatic half();
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic miso_of(input int inst);
    return (inst == 0) ? miso0 : (inst == 1) ? miso1 : miso2;
  endfunction

  task automatic set_ss(input int inst, input logic v);
    if (inst == 0) ss0 = v;
    else if (inst == 1) ss1 = v;
    else ss2 = v;
  endtask

  task automatic put_tx(input int inst, input logic [15:0] d);
    if (inst == 0) begin tx_data0 = d[7:0]; tx_valid0 = 1'b1; end
    else if (inst == 1) begin tx_data1 = d; tx_valid1 = 1'b1; end
    else begin tx_data2 = d[7:0]; tx_valid2 = 1'b1; end
    @(posedge clk);
    #1;
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    tx_valid2 = 1'b0;
    check("tx_ready_after_write", (inst == 0) ? tx_ready0 : (inst == 1) ? tx_ready1 : tx_ready2, 0);
  endtask

  task automatic take_rx(input int inst);
    if (inst == 0) rx_ready0 = 1'b1; else rx_ready2 = 1'b1;
    @(posedge clk);
    #1;
    rx_ready0 = 1'b0;
    rx_ready2 = 1'b0;
    check("rx_valid_clear", (inst == 0) ? rx_valid0 : rx_valid2, 0);
  endtask

  task automatic frame_begin(input int inst);
    set_ss(inst, 1'b0);
    half();
  endtask

  task automatic frame_end(input int inst);
    half();
    set_ss(inst, 1'b1);
    half();
    half();
  endtask

  // Master side: drives nbits bits of mo and collects miso into mi.
  task automatic spi_bits(input int inst, input int w, input int nbits, input bit cpol,
                          input bit cpha, input bit lsb, input logic [15:0] mo,
                          output logic [15:0] mi, output logic first);
    logic b;
    int   idx;
    mi    = '0;
    first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : (w - 1 - i);
      if (!cpha) begin
        mosi = mo[idx];
        half();
        b    = miso_of(inst);
        sclk = ~cpol;
        half();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[idx];
        half();
        b    = miso_of(inst);
        sclk = cpol;
        half();
      end
      mi[idx] = b;
      if (i == 0) first = b;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int u0, o0, a0, u1, o1;
    logic [15:0] mi;
    logic fb;

    tbl[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
    tbl[1] = '{8'h00, 1'b0, 8'h81, 8'h00, 8'h81, 1};
    tbl[2] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'h00, 0};
    tbl[3] = '{8'h69, 1'b1, 8'h96, 8'h69, 8'h96, 0};

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss0 = 1'b1; ss1 = 1'b1; ss2 = 1'b1;
    tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;
    tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0;
    rx_ready0 = 1'b0; rx_ready1 = 1'b1; rx_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", miso0, 0);
    check("rst_miso_oe", oe0, 0);
    check("rst_tx_ready", tx_ready0, 1);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_rx_data", rx_data0, 0);
    check("rst_busy", busy0, 0);
    check("rst_pulses", {urun0, ovr0, abort0}, 0);
    rst = 1'b0;
    half();
    half();
    check("idle_after_rst", busy0, 0);

    // Single mode-0 frames from the vector table.
    for (int k = 0; k < 4; k++) begin
      if (tbl[k].tx_en) put_tx(0, {8'h00, tbl[k].tx});
      u0 = n_urun0; o0 = n_ovr0; a0 = n_abort0;
      frame_begin(0);
      check("busy_in_frame", busy0, 1);
      check("oe_in_frame", oe0, 1);
      spi_bits(0, 8, 8, 1'b0, 1'b0, 1'b0, {8'h00, tbl[k].mo}, mi, fb);
      frame_end(0);
      check("tbl_miso_word", mi[7:0], tbl[k].exp_mi);
      check("tbl_rx_valid", rx_valid0, 1);
      check("tbl_rx_data", rx_data0, tbl[k].exp_rx);
      check("tbl_underrun", n_urun0 - u0, tbl[k].exp_urun);
      check("tbl_overrun", n_ovr0 - o0, 0);
      check("tbl_abort", n_abort0 - a0, 0);
      check("tbl_busy_end", busy0, 0);
      take_rx(0);
    end

    // Overrun: consumer not ready for two frames.
    o0 = n_ovr0;
    frame_begin(0);
    spi_bits(0, 8, 8, 1'b0, 1'b0, 1'b0, 16'h0011, mi, fb);
    frame_end(0);
    check("ovr_none_yet", n_ovr0 - o0, 0);
    frame_begin(0);
    spi_bits(0, 8, 8, 1'b0, 1'b0, 1'b0, 16'h0022, mi, fb);
    frame_end(0);
    check("ovr_rx_data_kept", rx_data0, 8'h11);
    check("ovr_rx_valid", rx_valid0, 1);
    check("ovr_pulse", n_ovr0 - o0, 1);
    take_rx(0);

    // Abort after 5 bits, then a clean frame.
    a0 = n_abort0;
    frame_begin(0);
    spi_bits(0, 8, 5, 1'b0, 1'b0, 1'b0, 16'h00FF, mi, fb);
    frame_end(0);
    check("abort_pulse", n_abort0 - a0, 1);
    check("abort_rx_valid", rx_valid0, 0);
    check("abort_busy", busy0, 0);
    put_tx(0, 16'h0096);
    frame_begin(0);
    spi_bits(0, 8, 8, 1'b0, 1'b0, 1'b0, 16'h005A, mi, fb);
    frame_end(0);
    check("post_abort_rx", rx_data0, 8'h5A);
    check("post_abort_miso", mi[7:0], 8'h96);
    check("post_abort_no_abort", n_abort0 - a0, 1);
    take_rx(0);

    // Reset mid-frame with ss held low.
    frame_begin(0);
    put_tx(0, 16'h0077);
    spi_bits(0, 8, 3, 1'b0, 1'b0, 1'b0, 16'h00C3, mi, fb);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_miso_oe", oe0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_miso", miso0, 0);
    check("midrst_tx_ready", tx_ready0, 1);
    check("midrst_rx_data", rx_data0, 0);
    spi_bits(0, 8, 8, 1'b0, 1'b0, 1'b0, 16'h00FF, mi, fb);
    half();
    check("midrst_no_frame_busy", busy0, 0);
    check("midrst_no_frame_rx", rx_valid0, 0);
    set_ss(0, 1'b1);
    half();
    half();
    put_tx(0, 16'h003C);
    frame_begin(0);
    spi_bits(0, 8, 8, 1'b0, 1'b0, 1'b0, 16'h00C3, mi, fb);
    frame_end(0);
    check("midrst_rx_after", rx_data0, 8'hC3);
    check("midrst_miso_after", mi[7:0], 8'h3C);
    take_rx(0);

    // Mode 3, 16-bit, two back-to-back words.
    sclk = 1'b1;
    half();
    half();
    u1 = n_urun1; o1 = n_ovr1;
    put_tx(1, 16'h1234);
    frame_begin(1);
    check("m3_tx_ready_after_load", tx_ready1, 1);
    put_tx(1, 16'hBEEF);
    spi_bits(1, 16, 16, 1'b1, 1'b1, 1'b0, 16'hCAFE, mi, fb);
    check("m3_miso_w0", mi, 16'h1234);
    check("m3_tx_ready_after_reload", tx_ready1, 1);
    spi_bits(1, 16, 16, 1'b1, 1'b1, 1'b0, 16'h0F0F, mi, fb);
    check("m3_miso_w1", mi, 16'hBEEF);
    frame_end(1);
    check("m3_rx_count", rxq1.size(), 2);
    check("m3_rx_w0", (rxq1.size() > 0) ? rxq1[0] : 16'hDEAD, 16'hCAFE);
    check("m3_rx_w1", (rxq1.size() > 1) ? rxq1[1] : 16'hDEAD, 16'h0F0F);
    check("m3_underrun", n_urun1 - u1, 0);
    check("m3_overrun", n_ovr1 - o1, 0);
    sclk = 1'b0;
    half();
    half();

    // LSB-first instance.
    put_tx(2, 16'h0001);
    frame_begin(2);
    spi_bits(2, 8, 8, 1'b0, 1'b0, 1'b1, 16'h0001, mi, fb);
    frame_end(2);
    check("lsb_first_bit", fb, 1);
    check("lsb_miso_word", mi[7:0], 8'h01);
    check("lsb_rx_data", rx_data2, 8'h01);
    check("lsb_rx_valid", rx_valid2, 1);
    take_rx(2);
    put_tx(2, 16'h0035);
    frame_begin(2);
    spi_bits(2, 8, 8, 1'b0, 1'b0, 1'b1, 16'h00C1, mi, fb);
    frame_end(2);
    check("lsb_miso_word2", mi[7:0], 8'h35);
    check("lsb_rx_data2", rx_data2, 8'hC1);
    take_rx(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
